// File: rtl/xmtr_arb_pkg.sv
// -----------------------------------------------------------------------------
// xmtr_arb_pkg
// Definitions shared by the serial frame transmitter (xmtr_arb) and its
// receiver (rcvr). These are the default frame geometry, the FSM state
// encoding and a frame-length helper.
// -----------------------------------------------------------------------------
package xmtr_arb_pkg;

  localparam int         HEADER_SIZE_DEF  = 8;
  localparam logic [7:0] HEADER_VALUE_DEF = 8'hA5;
  localparam int         BODY_SIZE_DEF    = 16;
  localparam int         GAP_SIZE_DEF     = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } xmtr_state_t;

  // Number of bits serialised per frame: header followed by body.
  function automatic int frame_bits(input int hdr_size, input int body_size);
    return hdr_size + body_size;
  endfunction

endpackage

// File: rtl/xmtr_arb_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-input round-robin arbiter with a one-hot grant.
//   i_clk   : clock, rising edge
//   i_rst   : synchronous active-high reset (last-granted pointer -> 1)
//   i_req   : request vector, bit n = requester n
//   i_take  : the current grant is consumed, so the pointer is updated
//   o_grant : one-hot grant (combinational from i_req and the pointer)
// -----------------------------------------------------------------------------
module rr_arb2 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic       i_take,
  output logic [1:0] o_grant
);

  // 1 means requester 1 was granted last. A tie then goes to requester 0.
  logic r_last;

  // Grant selection. A lone requester always wins. On a tie the requester
  // that was not granted last wins.
  always_comb begin
    o_grant = 2'b00;
    case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = r_last ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

  // Last-granted pointer. It moves only when a grant is actually consumed.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last <= 1'b1;
    end else if (i_take && (o_grant != 2'b00)) begin
      r_last <= o_grant[1];
    end else begin
      r_last <= r_last;
    end
  end

endmodule

// File: rtl/xmtr_arb.sv
// -----------------------------------------------------------------------------
// xmtr_arb
// Arbitrates between two frame requesters and serialises the winner's frame
// as {HEADER_VALUE, DINx}, MSB first. After each frame it sends GAP_SIZE
// idle bits.
//   i_sclk        : clock, all state changes on the rising edge
//   i_rst         : synchronous active-high reset
//   i_req0/i_req1 : frame requests, held until the matching grant
//   i_din0/i_din1 : frame bodies, captured on the grant edge
//   o_gnt0/o_gnt1 : one-cycle grant pulses (body captured)
//   o_sdata       : serial stream, one bit per clock
//   o_busy        : high in SEND and GAP
//   o_frame_cnt   : completed frames, modulo 256
// All outputs are registered.
// -----------------------------------------------------------------------------
module xmtr_arb
  import xmtr_arb_pkg::*;
#(
  parameter int                     HEADER_SIZE  = HEADER_SIZE_DEF,
  parameter logic [HEADER_SIZE-1:0] HEADER_VALUE = HEADER_VALUE_DEF,
  parameter int                     BODY_SIZE    = BODY_SIZE_DEF,
  parameter int                     GAP_SIZE     = GAP_SIZE_DEF
) (
  input  logic                 i_sclk,
  input  logic                 i_rst,
  input  logic                 i_req0,
  input  logic [BODY_SIZE-1:0] i_din0,
  output logic                 o_gnt0,
  input  logic                 i_req1,
  input  logic [BODY_SIZE-1:0] i_din1,
  output logic                 o_gnt1,
  output logic                 o_sdata,
  output logic                 o_busy,
  output logic [7:0]           o_frame_cnt
);

  localparam int FRAME_LEN = frame_bits(HEADER_SIZE, BODY_SIZE);
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);

  xmtr_state_t          r_state;
  logic [FRAME_LEN-1:0] r_shreg;
  logic [CNT_W-1:0]     r_bitcnt;
  logic [3:0]           r_gapcnt;
  logic                 r_gnt0;
  logic                 r_gnt1;
  logic                 r_sdata;
  logic                 r_busy;
  logic [7:0]           r_frame_cnt;

  logic [1:0]           w_grant;
  logic                 w_take;
  logic [FRAME_LEN-1:0] w_frame;

  // Requests are only looked at in IDLE. Changes while busy are ignored.
  assign w_take = (r_state == ST_IDLE);

  rr_arb2 u_rr_arb2 (
    .i_clk   (i_sclk),
    .i_rst   (i_rst),
    .i_req   ({i_req1, i_req0}),
    .i_take  (w_take),
    .o_grant (w_grant)
  );

  // Frame image of the requester that wins this cycle.
  always_comb begin
    w_frame = {HEADER_VALUE, i_din0};
    if (w_grant[1]) begin
      w_frame = {HEADER_VALUE, i_din1};
    end else begin
      w_frame = {HEADER_VALUE, i_din0};
    end
  end

  // Transmit FSM. The frame MSB goes straight into r_sdata on the grant edge.
  // The shift register therefore holds the remaining bits, and r_bitcnt
  // counts the bits already placed on the line.
  always_ff @(posedge i_sclk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_shreg     <= '0;
      r_bitcnt    <= '0;
      r_gapcnt    <= 4'd0;
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_sdata     <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_cnt <= 8'd0;
    end else begin
      r_gnt0 <= 1'b0;
      r_gnt1 <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant != 2'b00) begin
            r_state  <= ST_SEND;
            r_busy   <= 1'b1;
            r_gnt0   <= w_grant[0];
            r_gnt1   <= w_grant[1];
            r_sdata  <= w_frame[FRAME_LEN-1];
            r_shreg  <= {w_frame[FRAME_LEN-2:0], 1'b0};
            r_bitcnt <= CNT_W'(1);
          end else begin
            r_sdata <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        ST_SEND: begin
          if (r_bitcnt == CNT_W'(FRAME_LEN)) begin
            // The last bit has been on the line for one cycle, so the frame is done.
            r_state     <= ST_GAP;
            r_sdata     <= 1'b0;
            r_bitcnt    <= '0;
            r_gapcnt    <= 4'd1;
            r_frame_cnt <= r_frame_cnt + 8'd1;
          end else begin
            r_sdata  <= r_shreg[FRAME_LEN-1];
            r_shreg  <= {r_shreg[FRAME_LEN-2:0], 1'b0};
            r_bitcnt <= r_bitcnt + CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (r_gapcnt == 4'(GAP_SIZE)) begin
            r_state  <= ST_IDLE;
            r_busy   <= 1'b0;
            r_gapcnt <= 4'd0;
          end else begin
            r_gapcnt <= r_gapcnt + 4'd1;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_sdata  <= 1'b0;
          r_busy   <= 1'b0;
          r_bitcnt <= '0;
          r_gapcnt <= 4'd0;
        end
      endcase
    end
  end

  assign o_gnt0      = r_gnt0;
  assign o_gnt1      = r_gnt1;
  assign o_sdata     = r_sdata;
  assign o_busy      = r_busy;
  assign o_frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_xmtr_arb.sv
// -----------------------------------------------------------------------------
// tb_xmtr_arb
// Self-checking bench for xmtr_arb. A cycle-indexed frame model predicts
// every output. A bench-side receiver deserialises SDATA and hands each
// completed frame over with a READY/ACK handshake.
// -----------------------------------------------------------------------------
module tb_xmtr_arb;

  localparam int L = 24;  // header + body bits
  localparam int G = 2;   // gap bits
  localparam int P = 27;  // frame-to-frame period

  logic        clk = 1'b0;
  logic        rst, req0, req1;
  logic [15:0] din0, din1;
  logic        gnt0, gnt1, sdata, busy;
  logic [7:0]  fcnt;

  always #5 clk = ~clk;

  xmtr_arb #(
    .HEADER_SIZE (8),
    .HEADER_VALUE(8'hA5),
    .BODY_SIZE   (16),
    .GAP_SIZE    (2)
  ) dut (
    .i_sclk     (clk),
    .i_rst      (rst),
    .i_req0     (req0),
    .i_din0     (din0),
    .o_gnt0     (gnt0),
    .i_req1     (req1),
    .i_din1     (din1),
    .o_gnt1     (gnt1),
    .o_sdata    (sdata),
    .o_busy     (busy),
    .o_frame_cnt(fcnt)
  );

  int n_err = 0;
  int n_chk = 0;
  int cyc   = 0;

  // Model: m_k = cycle index since the last grant edge (-1 = idle).
  int          m_k = -1;
  int          m_last = 1;
  int          m_win = 0;
  int          m_cnt = 0;
  int          m_ng = 0;
  logic [23:0] m_frame = 24'd0;

  // Receiver: shift in the frame bits, then raise READY until ACK.
  logic [23:0] rx_sh = 24'd0;
  logic [15:0] rx_last = 16'd0;
  int          rx_cnt = 0;
  bit          rx_ready = 1'b0;
  bit          rx_ack;

  int   g_id[$];
  int   g_cyc[$];
  logic [7:0] prev_cnt = 8'd0;
  bit   saw255, wrap_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_k = -1; m_last = 1; m_cnt = 0;
    end else if (m_k < 0 || m_k >= L + G) begin
      if (req0 || req1) begin
        if (req0 && req1) m_win = (m_last == 1) ? 0 : 1;
        else              m_win = req1 ? 1 : 0;
        m_last  = m_win;
        m_frame = {8'hA5, (m_win == 1) ? din1 : din0};
        m_k     = 0;
        m_ng++;
      end else begin
        m_k = -1;
      end
    end else begin
      m_k++;
      if (m_k == L) m_cnt = (m_cnt + 1) % 256;
    end
  endtask

  task automatic step();
    logic e_sd;
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    e_sd = (m_k >= 0 && m_k < L) ? m_frame[L-1-m_k] : 1'b0;
    chk("gnt0", 32'(gnt0), 32'((m_k == 0 && m_win == 0) ? 1 : 0));
    chk("gnt1", 32'(gnt1), 32'((m_k == 0 && m_win == 1) ? 1 : 0));
    chk("gnt_both", 32'(gnt0 & gnt1), 32'd0);
    chk("sdata", 32'(sdata), 32'(e_sd));
    chk("busy", 32'(busy), 32'((m_k >= 0 && m_k < L + G) ? 1 : 0));
    chk("frame_cnt", 32'(fcnt), 32'(m_cnt));
    if (gnt0 || gnt1) begin
      g_id.push_back(gnt1 ? 1 : 0);
      g_cyc.push_back(cyc);
    end
    if (rst) rx_ready = 1'b0;
    rx_ack = rx_ready;  // consumer always accepts one cycle after READY
    if (rx_ack) rx_ready = 1'b0;
    if (m_k >= 0 && m_k < L) rx_sh = {rx_sh[22:0], sdata};
    if (m_k == L - 1 && !rst) begin
      rx_ready = 1'b1;
      rx_cnt++;
      rx_last = rx_sh[15:0];
      chk("rx_header", 32'(rx_sh[23:16]), 32'h0000_00A5);
      chk("rx_byte_hi", 32'(rx_sh[15:8]), 32'(m_frame[15:8]));
      chk("rx_byte_lo", 32'(rx_sh[7:0]), 32'(m_frame[7:0]));
    end
    if (fcnt == 8'd255) saw255 = 1'b1;
    if (prev_cnt == 8'd255 && fcnt == 8'd0) wrap_seen = 1'b1;
    prev_cnt = fcnt;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); step(); rst = 1'b0;
  endtask

  initial begin
    int rx0, ng0, gq0, gwin;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; din0 = 16'd0; din1 = 16'd0;

    // Reset state
    step(); step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cnt", 32'(fcnt), 32'd0);
    rst = 1'b0;
    steps(3);

    // Single frame from requester 0; REQ0 drops in the grant cycle
    req0 = 1'b1; din0 = 16'h3524;
    step();
    chk("t1_gnt0", 32'(gnt0), 32'd1);
    req0 = 1'b0;
    steps(30);
    chk("t1_rx_body", 32'(rx_last), 32'h0000_3524);
    chk("t1_cnt", 32'(fcnt), 32'd1);
    chk("t1_single_grant", 32'(g_id.size()), 32'd1);

    // Simultaneous requests after reset: 0 first, 1 exactly one period later
    do_reset();
    g_id.delete(); g_cyc.delete();
    req0 = 1'b1; req1 = 1'b1; din0 = 16'h5E81; din1 = 16'hD609;
    for (int i = 0; i < 80 && (req0 || req1); i++) begin
      step();
      if (m_k == 0 && m_win == 0) req0 = 1'b0;
      if (m_k == 0 && m_win == 1) req1 = 1'b0;
    end
    chk("t2_timeout", 32'(req0 | req1), 32'd0);
    steps(30);
    chk("t2_ngrants", 32'(g_id.size()), 32'd2);
    if (g_id.size() == 2) begin
      chk("t2_first", 32'(g_id[0]), 32'd0);
      chk("t2_second", 32'(g_id[1]), 32'd1);
      chk("t2_spacing", 32'(g_cyc[1] - g_cyc[0]), 32'(P));
    end
    chk("t2_rx_last", 32'(rx_last), 32'h0000_D609);

    // Both held for four frames: 0,1,0,1
    do_reset();
    g_id.delete(); g_cyc.delete();
    ng0 = m_ng;
    req0 = 1'b1; req1 = 1'b1; din0 = 16'h1234; din1 = 16'hABCD;
    for (int i = 0; i < 200 && (m_ng - ng0) < 4; i++) step();
    req0 = 1'b0; req1 = 1'b0;
    steps(30);
    chk("t3_ngrants", 32'(g_id.size()), 32'd4);
    if (g_id.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("t3_order", 32'(g_id[i]), 32'(i % 2));
    end
    chk("t3_cnt", 32'(fcnt), 32'd4);

    // Reset at body bit 10 abandons the frame
    do_reset();
    rx0 = rx_cnt;
    req0 = 1'b1; din0 = 16'h5663;
    step();
    req0 = 1'b0;
    for (int i = 0; i < 40 && m_k < 18; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t4_sdata", 32'(sdata), 32'd0);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_cnt", 32'(fcnt), 32'd0);
    steps(30);
    chk("t4_no_rx", 32'(rx_cnt), 32'(rx0));

    // 256 back-to-back frames from requester 1, DIN1 noise while busy
    do_reset();
    saw255 = 1'b0; wrap_seen = 1'b0;
    ng0 = m_ng;
    req1 = 1'b1; din1 = 16'($urandom);
    for (int i = 0; i < 256 * P + 20 && (m_ng - ng0) < 256; i++) begin
      step();
      if (m_k >= 1 && m_k <= L + G - 1) din1 = 16'($urandom);
    end
    req1 = 1'b0;
    steps(30);
    chk("t5_saw255", 32'(saw255), 32'd1);
    chk("t5_wrap", 32'(wrap_seen), 32'd1);
    chk("t5_cnt", 32'(fcnt), 32'd0);

    // REQ1 raised and dropped while busy gets no grant
    gq0 = g_id.size();
    req0 = 1'b1; din0 = 16'($urandom);
    step();
    req0 = 1'b0;
    steps(3);
    req1 = 1'b1;
    steps(10);
    req1 = 1'b0;
    steps(30);
    chk("t6_no_gnt1", 32'(g_id.size() - gq0), 32'd1);
    chk("t6_busy", 32'(busy), 32'd0);

    // Random traffic, occasional reset
    for (int i = 0; i < 1500; i++) begin
      step();
      gwin = (m_k == 0) ? m_win : -1;
      rst = ($urandom_range(0, 299) == 0);
      if (!req0 && $urandom_range(0, 7) == 0) begin req0 = 1'b1; din0 = 16'($urandom); end
      else if (gwin == 0 && $urandom_range(0, 1) == 0) req0 = 1'b0;
      else if (busy && $urandom_range(0, 39) == 0) req0 = 1'b0;
      if (!req1 && $urandom_range(0, 7) == 0) begin req1 = 1'b1; din1 = 16'($urandom); end
      else if (gwin == 1 && $urandom_range(0, 1) == 0) req1 = 1'b0;
      else if (busy && $urandom_range(0, 39) == 0) req1 = 1'b0;
    end
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    steps(30);
    chk("end_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
